// File: rtl/fib_arbiter.sv
// fib_arbiter: round-robin front end that shares one Fibonacci engine between
// NUM_REQ requesters, filters out arguments whose result would overflow RES_W
// bits, and returns each result to its requester as a one-cycle pulse.
module fib_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ARG_W   = 8,
    parameter int RES_W   = 16,
    parameter int MAX_ARG = 24
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*ARG_W-1:0] req_arg,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [RES_W-1:0]         rsp_result,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     fib_start,
    output logic [ARG_W-1:0]         fib_arg,
    input  logic                     fib_done,
    input  logic [RES_W-1:0]         fib_result
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [ARG_W-1:0] MAX_ARG_V = ARG_W'(MAX_ARG);

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] gnt_q, gnt_d;
    logic [ARG_W-1:0] arg_q, arg_d;
    logic [RES_W-1:0] res_q, res_d;
    logic             err_q, err_d;

    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [ARG_W-1:0]   grant_arg;
    logic [NUM_REQ-1:0] grant_vec;
    logic [NUM_REQ-1:0] rsp_vec;
    logic [PTR_W-1:0]   cand;

    // Round-robin search starting just after the last winner; scanning from the
    // lowest priority upwards lets the highest-priority hit overwrite the rest.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
            if (req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        grant_arg = req_arg[grant_idx*ARG_W +: ARG_W];
    end

    // One-hot decode of the current grant and of the requester being answered.
    always_comb begin
        grant_vec = '0;
        rsp_vec   = '0;
        grant_vec[grant_idx] = 1'b1;
        rsp_vec[gnt_q]       = 1'b1;
    end

    // Next-state logic for the IDLE/ISSUE/WAIT/RESP sequence.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        arg_d   = arg_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    gnt_d = grant_idx;
                    ptr_d = grant_idx;
                    arg_d = grant_arg;
                    if (grant_arg > MAX_ARG_V) begin
                        res_d   = '1;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fib_done) begin
                    res_d   = fib_result;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any in-flight request and gives requester 0 first priority.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            gnt_q   <= '0;
            arg_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            arg_q   <= arg_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // Output decode; ready is masked by reset so no handshake completes while reset is held.
    always_comb begin
        req_ready  = (state_q == ST_IDLE && grant_found && i_rst_n) ? grant_vec : '0;
        rsp_valid  = (state_q == ST_RESP) ? rsp_vec : '0;
        rsp_result = res_q;
        rsp_err    = err_q;
        busy       = (state_q != ST_IDLE);
        fib_start  = (state_q == ST_ISSUE);
        fib_arg    = arg_q;
    end

endmodule

// File: tb/tb_fib_arbiter.sv
// tb_fib_arbiter: drives fib_arbiter with directed and randomized requests,
// emulates the Fibonacci engine, and compares every cycle against a
// transaction-level model built from grant order and per-argument latency.
module tb_fib_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ARG_W   = 8;
    localparam int RES_W   = 16;
    localparam int MAX_ARG = 24;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*ARG_W-1:0] req_arg;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [RES_W-1:0]         rsp_result;
    logic                     rsp_err;
    logic                     busy;
    logic                     fib_start;
    logic [ARG_W-1:0]         fib_arg;
    logic                     fib_done;
    logic [RES_W-1:0]         fib_result;

    int nCompared   = 0;
    int nMismatched = 0;

    fib_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ARG_W  (ARG_W),
        .RES_W  (RES_W),
        .MAX_ARG(MAX_ARG)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .req_valid (req_valid),
        .req_arg   (req_arg),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_result(rsp_result),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .fib_start (fib_start),
        .fib_arg   (fib_arg),
        .fib_done  (fib_done),
        .fib_result(fib_result)
    );

    always #5 clk = ~clk;

    // Plain iterative Fibonacci used by both the engine stand-in and the model.
    function automatic longint fibRef(input int n);
        longint a = 0;
        longint b = 1;
        longint t;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Engine stand-in: done rises max(arg,1) cycles after the start cycle and stays high until the next start.
    int engRemain;
    logic engRunning;
    always @(posedge clk) begin
        if (!rst_n) begin
            fib_done   <= 1'b0;
            fib_result <= '0;
            engRunning <= 1'b0;
            engRemain  <= 0;
        end else if (fib_start) begin
            fib_result <= RES_W'(fibRef(int'(fib_arg)));
            engRemain  <= ((fib_arg < 2) ? 1 : int'(fib_arg)) - 1;
            fib_done   <= (fib_arg < 2);
            engRunning <= (fib_arg >= 2);
        end else if (engRunning) begin
            engRemain <= engRemain - 1;
            if (engRemain == 1) begin
                fib_done   <= 1'b1;
                engRunning <= 1'b0;
            end
        end
    end

    // Reference model: tracks when the arbiter is next free, who is served, and when each pulse is due.
    int cyc = 0;
    int mFreeAt = 0;
    int mRspAt = -1;
    int mStartAt = -1;
    int mRspReq = 0;
    int mPtr = NUM_REQ - 1;
    int mStartArg = 0;
    logic [RES_W-1:0] mPendRes = '0;
    logic             mPendErr = 1'b0;
    logic [RES_W-1:0] mHeldRes = '0;
    logic             mHeldErr = 1'b0;
    logic inResetPrev = 1'b0;
    logic [NUM_REQ-1:0] lastHs = '0;

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] expReady;
        logic [NUM_REQ-1:0] expRsp;
        logic expBusy;
        logic expStart;
        int g;
        int a;
        int lat;
        cyc++;
        if (!rst_n) begin
            checkOutput("rstReady", 32'(req_ready), 32'd0);
            if (inResetPrev) begin
                checkOutput("rstRspValid", 32'(rsp_valid), 32'd0);
                checkOutput("rstStart", 32'(fib_start), 32'd0);
                checkOutput("rstBusy", 32'(busy), 32'd0);
                checkOutput("rstResult", 32'(rsp_result), 32'd0);
                checkOutput("rstErr", 32'(rsp_err), 32'd0);
            end
            inResetPrev = 1'b1;
            mFreeAt  = cyc + 1;
            mRspAt   = -1;
            mStartAt = -1;
            mPtr     = NUM_REQ - 1;
            mHeldRes = '0;
            mHeldErr = 1'b0;
            lastHs   = '0;
        end else begin
            inResetPrev = 1'b0;
            expBusy  = (cyc < mFreeAt);
            expRsp   = '0;
            expStart = (cyc == mStartAt);
            if (cyc == mRspAt) begin
                expRsp[mRspReq] = 1'b1;
                mHeldRes = mPendRes;
                mHeldErr = mPendErr;
            end
            if (expStart) begin
                checkOutput("fibArg", 32'(fib_arg), 32'(mStartArg));
            end
            expReady = '0;
            if (!expBusy) begin
                g = -1;
                for (int i = 1; i <= NUM_REQ; i++) begin
                    if (g < 0 && req_valid[(mPtr + i) % NUM_REQ]) g = (mPtr + i) % NUM_REQ;
                end
                if (g >= 0) begin
                    expReady[g] = 1'b1;
                    a = int'(req_arg[g*ARG_W +: ARG_W]);
                    if (a > MAX_ARG) begin
                        lat      = 1;
                        mPendRes = '1;
                        mPendErr = 1'b1;
                        mStartAt = -1;
                    end else begin
                        lat      = (a < 2) ? 3 : a + 2;
                        mPendRes = RES_W'(fibRef(a));
                        mPendErr = 1'b0;
                        mStartAt = cyc + 1;
                    end
                    mStartArg = a;
                    mRspAt    = cyc + lat;
                    mRspReq   = g;
                    mFreeAt   = cyc + lat + 1;
                    mPtr      = g;
                end
            end
            checkOutput("reqReady", 32'(req_ready), 32'(expReady));
            checkOutput("rspValid", 32'(rsp_valid), 32'(expRsp));
            checkOutput("busy", 32'(busy), 32'(expBusy));
            checkOutput("fibStart", 32'(fib_start), 32'(expStart));
            checkOutput("rspResult", 32'(rsp_result), 32'(mHeldRes));
            checkOutput("rspErr", 32'(rsp_err), 32'(mHeldErr));
            lastHs = req_valid & req_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise one request, drop it after its handshake, and let the model judge the outcome.
    task automatic applyStimulus(input int k, input int arg, input int cycles);
        req_arg[k*ARG_W +: ARG_W] = ARG_W'(arg);
        req_valid[k] = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (lastHs[k]) req_valid[k] = 1'b0;
        end
        req_valid[k] = 1'b0;
    endtask

    task automatic raiseRandom(input int k);
        req_arg[k*ARG_W +: ARG_W] = ARG_W'($urandom_range(0, 30));
        req_valid[k] = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_arg   = '0;
        req_arg[0*ARG_W +: ARG_W] = 8'd3;
        req_arg[1*ARG_W +: ARG_W] = 8'd4;
        req_arg[2*ARG_W +: ARG_W] = 8'd5;
        req_arg[3*ARG_W +: ARG_W] = 8'd6;

        $display("[TB] reset with every requester valid");
        repeat (2) tick();
        rst_n = 1'b1;

        $display("[TB] round-robin with all four requesters held valid");
        repeat (70) tick();
        req_valid = '0;
        repeat (10) tick();

        $display("[TB] directed single requests");
        applyStimulus(1, 10, 20);
        applyStimulus(0, 24, 32);
        applyStimulus(2, 0, 6);
        applyStimulus(3, 1, 6);
        applyStimulus(1, 2, 7);
        applyStimulus(2, 25, 4);
        applyStimulus(0, 24, 32);
        applyStimulus(3, 255, 4);

        $display("[TB] reset during WAIT");
        applyStimulus(2, 20, 8);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        applyStimulus(3, 5, 12);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 4000; c++) begin
            tick();
            for (int k = 0; k < NUM_REQ; k++) begin
                if (lastHs[k]) begin
                    req_valid[k] = 1'b0;
                    if ($urandom_range(0, 3) == 0) raiseRandom(k);
                end else if (!req_valid[k]) begin
                    if ($urandom_range(0, 7) == 0) raiseRandom(k);
                end else if ($urandom_range(0, 99) == 0) begin
                    req_valid[k] = 1'b0;
                end
            end
            if ($urandom_range(0, 699) == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
                rst_n = 1'b1;
            end
        end
        req_valid = '0;
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
